// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave bridging to a simple register file: independent write and
// read FSMs, single-cycle write strobe and registered read index/capture.
`timescale 1ns/1ps
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ADDR_WIDTH-1:0]     write_addr,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      write_en,
  output logic [ADDR_WIDTH-1:0]     read_addr,
  input  logic [DATA_WIDTH-1:0]     read_data
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_CAPTURE, R_DATA} rstate_e;

  function automatic logic addr_oor(input logic [AXI_ADDR_WIDTH-1:0] a);
    return |(a >> (ADDR_WIDTH + 2));
  endfunction

  wstate_e                 w_state_q;
  rstate_e                 r_state_q;
  logic                    aw_lat_q, w_lat_q, aw_oor_q, ar_oor_q;
  logic [ADDR_WIDTH-1:0]   aw_idx_q, write_addr_q, read_addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, write_data_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    write_en_q, bvalid_q, rvalid_q;
  logic [1:0]              bresp_q, rresp_q;

  // Byte-offset bits never affect decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies are gated by resetn so they read 0 in reset and 1 right after release.
  assign s_axi_awready = resetn && (w_state_q == W_IDLE) && !aw_lat_q;
  assign s_axi_wready  = resetn && (w_state_q == W_IDLE) && !w_lat_q;
  assign s_axi_arready = resetn && (r_state_q == R_IDLE);

  logic aw_hs, w_hs, ar_hs, wr_go, wr_ok;
  logic [ADDR_WIDTH-1:0]   aw_idx_eff;
  logic [DATA_WIDTH-1:0]   wdata_eff;
  logic [DATA_WIDTH/8-1:0] wstrb_eff;
  logic                    aw_oor_eff;

  always_comb begin
    aw_hs      = s_axi_awvalid && s_axi_awready;
    w_hs       = s_axi_wvalid && s_axi_wready;
    ar_hs      = s_axi_arvalid && s_axi_arready;
    aw_idx_eff = aw_lat_q ? aw_idx_q : s_axi_awaddr[ADDR_WIDTH+1:2];
    aw_oor_eff = aw_lat_q ? aw_oor_q : addr_oor(s_axi_awaddr);
    wdata_eff  = w_lat_q  ? wdata_q  : s_axi_wdata;
    wstrb_eff  = w_lat_q  ? wstrb_q  : s_axi_wstrb;
    wr_go      = (aw_lat_q || aw_hs) && (w_lat_q || w_hs);
    wr_ok      = !aw_oor_eff && (&wstrb_eff);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q    <= W_IDLE;
      aw_lat_q     <= 1'b0;
      w_lat_q      <= 1'b0;
      aw_idx_q     <= '0;
      aw_oor_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
    end else begin
      write_en_q <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_lat_q <= 1'b1;
            aw_idx_q <= s_axi_awaddr[ADDR_WIDTH+1:2];
            aw_oor_q <= addr_oor(s_axi_awaddr);
          end
          if (w_hs) begin
            w_lat_q <= 1'b1;
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
          end
          if (wr_go) begin
            w_state_q  <= W_WRITE;
            write_en_q <= wr_ok;
            if (wr_ok) begin
              write_addr_q <= aw_idx_eff;
              write_data_q <= wdata_eff;
            end
          end
        end
        W_WRITE: begin
          // write_en_q still reflects whether the write was performed.
          bvalid_q  <= 1'b1;
          bresp_q   <= write_en_q ? OKAY : SLVERR;
          w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q   <= R_IDLE;
      read_addr_q <= '0;
      ar_oor_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
      rvalid_q    <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            read_addr_q <= s_axi_araddr[ADDR_WIDTH+1:2];
            ar_oor_q    <= addr_oor(s_axi_araddr);
            r_state_q   <= R_CAPTURE;
          end
        end
        R_CAPTURE: begin
          rdata_q   <= ar_oor_q ? '0 : read_data;
          rresp_q   <= ar_oor_q ? SLVERR : OKAY;
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign write_en     = write_en_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign read_addr    = read_addr_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed scenarios plus randomized traffic
// checked against an array model of the register map.
`timescale 1ns/1ps
module tb_axi_lite_reg_slave;
  logic        clk = 1'b0, resetn = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, write_en;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, write_data, read_data;
  logic [3:0]  write_addr, read_addr;

  always #5 clk = ~clk;

  axi_lite_reg_slave dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .read_addr(read_addr), .read_data(read_data)
  );

  // Environment register file behind the slave.
  logic [31:0] regs [16];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_addr] <= write_data;
    end
  end
  assign read_data = regs[read_addr];

  int          we_cnt = 0;
  logic        we_prev = 1'b0, we_double = 1'b0;
  logic [3:0]  last_wa = '0;
  logic [31:0] last_wd = '0;
  always @(posedge clk) begin
    if (write_en) begin
      we_cnt  <= we_cnt + 1;
      last_wa <= write_addr;
      last_wd <= write_data;
    end
    if (write_en && we_prev) we_double <= 1'b1;
    we_prev <= write_en;
  end

  int vec = 0, errs = 0;
  logic [31:0] mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // W is offered w_lead cycles before AW (0 = same cycle).
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, output logic [1:0] resp, output logic ok);
    logic awd, wd, haw, hw;
    int n;
    awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0);
    awd = 1'b0; wd = 1'b0; n = 0; resp = 2'b11; ok = 1'b0;
    while (!(awd && wd) && n < 30) begin
      haw = awvalid && awready;
      hw  = wvalid && wready;
      tick(); n++;
      if (haw) begin awd = 1'b1; awvalid = 1'b0; end
      if (hw)  begin wd = 1'b1;  wvalid = 1'b0; end
      if (n >= w_lead && !awd) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; n = 0;
    while (!bvalid && n < 10) begin tick(); n++; end
    resp = bresp;
    ok = awd && wd && bvalid;
    tick();
    bready = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input int hold, output logic [31:0] d,
                    output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 10) begin tick(); n++; end
    chk("rd_arready", {31'b0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid_n1", {31'b0, rvalid}, 32'd0);
    tick();
    chk("rd_rvalid_n2", {31'b0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    for (int k = 0; k < hold; k++) begin
      chk("rd_hold_arready", {31'b0, arready}, 32'd0);
      tick();
      chk("rd_hold_rdata", rdata, d);
      chk("rd_hold_rvalid", {31'b0, rvalid}, 32'd1);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rd_done_rvalid", {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic        ok, exp_ok;
    logic [31:0] d, rd_d;
    logic [7:0]  a;
    logic [3:0]  s;
    int          c0;

    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    #12;
    chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
    chk("rst_valids", {29'b0, bvalid, rvalid, write_en}, 32'd0);
    chk("rst_resps", {28'b0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_addrs", {24'b0, write_addr, read_addr}, 32'd0);
    @(negedge clk); resetn = 1'b1; #1;
    chk("post_rst_readies", {29'b0, awready, wready, arready}, 32'd7);
    tick();

    // AW and W together
    c0 = we_cnt;
    wr(8'h04, 32'hDEADBEEF, 4'hF, 0, resp, ok);
    mem[1] = 32'hDEADBEEF;
    chk("w1_ok", {31'b0, ok}, 32'd1);
    chk("w1_we_cnt", 32'(we_cnt - c0), 32'd1);
    chk("w1_addr", {28'b0, last_wa}, 32'd1);
    chk("w1_data", last_wd, 32'hDEADBEEF);
    chk("w1_bresp", {30'b0, resp}, 32'd0);

    // W three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready_drop", {31'b0, wready}, 32'd0);
    chk("wfirst_awready", {31'b0, awready}, 32'd1);
    tick(); tick();
    awaddr = 8'h00; awvalid = 1'b1;
    chk("wfirst_no_we_yet", {31'b0, write_en}, 32'd0);
    tick();
    awvalid = 1'b0;
    chk("wfirst_we", {31'b0, write_en}, 32'd1);
    chk("wfirst_waddr", {28'b0, write_addr}, 32'd0);
    chk("wfirst_wdata", write_data, 32'h12345678);
    mem[0] = 32'h12345678;
    bready = 1'b1;
    tick();
    chk("wfirst_bvalid", {31'b0, bvalid}, 32'd1);
    chk("wfirst_bresp", {30'b0, bresp}, 32'd0);
    tick();
    bready = 1'b0;

    // Error writes
    c0 = we_cnt;
    wr(8'h40, 32'h0BADBAD0, 4'hF, 0, resp, ok);
    chk("oor_we_cnt", 32'(we_cnt - c0), 32'd0);
    chk("oor_bresp", {30'b0, resp}, 32'd2);
    wr(8'h08, 32'hCAFEF00D, 4'hF, 1, resp, ok);
    mem[2] = 32'hCAFEF00D;
    c0 = we_cnt;
    wr(8'h08, 32'h99999999, 4'h3, 0, resp, ok);
    chk("strb_we_cnt", 32'(we_cnt - c0), 32'd0);
    chk("strb_bresp", {30'b0, resp}, 32'd2);
    rd(8'h08, 0, rd_d, resp);
    chk("strb_reg2_kept", rd_d, 32'hCAFEF00D);

    // Read with rready held off
    rd(8'h04, 5, rd_d, resp);
    chk("rd1_data", rd_d, 32'hDEADBEEF);
    chk("rd1_rresp", {30'b0, resp}, 32'd0);

    // Read capture colliding with write of same index
    wr(8'h0C, 32'h00000011, 4'hF, 0, resp, ok);
    mem[3] = 32'h11;
    awaddr = 8'h0C; wdata = 32'hAAAA5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h0C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_we", {31'b0, write_en}, 32'd1);
    tick();
    chk("coll_rvalid", {31'b0, rvalid}, 32'd1);
    chk("coll_rdata_old", rdata, 32'h11);
    chk("coll_bvalid", {31'b0, bvalid}, 32'd1);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    mem[3] = 32'hAAAA5555;
    rd(8'h0C, 0, rd_d, resp);
    chk("coll_rdata_new", rd_d, 32'hAAAA5555);

    // Randomized traffic against the array model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = {2'b00, 4'($urandom), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
        exp_ok = (a[7:6] == 2'b00) && (s == 4'hF);
        c0 = we_cnt;
        wr(a, d, s, int'($urandom_range(0, 2)), resp, ok);
        chk("rnd_wr_ok", {31'b0, ok}, 32'd1);
        chk("rnd_wr_bresp", {30'b0, resp}, exp_ok ? 32'd0 : 32'd2);
        chk("rnd_wr_we_cnt", 32'(we_cnt - c0), exp_ok ? 32'd1 : 32'd0);
        if (exp_ok) begin
          mem[a[5:2]] = d;
          chk("rnd_wr_addr", {28'b0, last_wa}, {28'b0, a[5:2]});
          chk("rnd_wr_data", last_wd, d);
        end
      end else begin
        rd(a, int'($urandom_range(0, 2)), rd_d, resp);
        if (a[7:6] == 2'b00) begin
          chk("rnd_rd_data", rd_d, mem[a[5:2]]);
          chk("rnd_rd_rresp", {30'b0, resp}, 32'd0);
        end else begin
          chk("rnd_rd_oor_data", rd_d, 32'd0);
          chk("rnd_rd_oor_rresp", {30'b0, resp}, 32'd2);
        end
      end
    end

    // Reset while in W_RESP and R_DATA
    awaddr = 8'h10; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h04; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    chk("mid_pre_bvalid", {31'b0, bvalid}, 32'd1);
    chk("mid_pre_rvalid", {31'b0, rvalid}, 32'd1);
    c0 = we_cnt;
    resetn = 1'b0; #1;
    chk("mid_rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
    chk("mid_rst_readies", {29'b0, awready, wready, arready}, 32'd0);
    tick(); tick();
    @(negedge clk); resetn = 1'b1; #1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    chk("mid_post_readies", {29'b0, awready, wready, arready}, 32'd7);
    bready = 1'b1; rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_no_stale", {29'b0, bvalid, rvalid, write_en}, 32'd0);
    end
    bready = 1'b0; rready = 1'b0;
    chk("mid_we_cnt", 32'(we_cnt - c0), 32'd0);
    rd(8'h04, 0, rd_d, resp);
    chk("mid_rd_cleared", rd_d, mem[1]);

    chk("we_never_double", {31'b0, we_double}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 The block SHALL have one clock `clk` and an asynchronous, active-low reset `resetn`; polarity and synchronicity are fixed.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- ADDR_WIDTH, 4, register index width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- AXI_ADDR_WIDTH, 8, AXI byte-address width.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- resetn, in, 1, async active-low reset.
- s_axi_awaddr, in, AXI_ADDR_WIDTH, write address.
- s_axi_awvalid / s_axi_awready, in / out, 1, AW handshake.
- s_axi_wdata, in, DATA_WIDTH, write data.
- s_axi_wstrb, in, DATA_WIDTH/8, write byte strobes.
- s_axi_wvalid / s_axi_wready, in / out, 1, W handshake.
- s_axi_bresp, out, 2, write response.
- s_axi_bvalid / s_axi_bready, out / in, 1, B handshake.
- s_axi_araddr, in, AXI_ADDR_WIDTH, read address.
- s_axi_arvalid / s_axi_arready, in / out, 1, AR handshake.
- s_axi_rdata, out, DATA_WIDTH, read data.
- s_axi_rresp, out, 2, read response.
- s_axi_rvalid / s_axi_rready, out / in, 1, R handshake.
- write_addr, out, ADDR_WIDTH, register-file write index.
- write_data, out, DATA_WIDTH, register-file write data.
- write_en, out, 1, single-cycle register-file write strobe.
- read_addr, out, ADDR_WIDTH, register-file read index (registered).
- read_data, in, DATA_WIDTH, register-file combinational read data.

Function
REQ-004 Address decode SHALL be as follows:
- Register index = addr[ADDR_WIDTH+1:2].
- addr[1:0] is ignored.
- Any 1 in addr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2] marks the address out-of-range.
REQ-005 The write path SHALL be an FSM with states W_IDLE, W_WRITE and W_RESP.
REQ-006 In W_IDLE, AW and W SHALL be accepted independently and in either order:
- awready = 1 while no AW is latched; wready = 1 while no W is latched.
- Each beat is latched on valid&&ready.
REQ-007 When both AW and W are latched, the FSM SHALL enter W_WRITE for exactly one cycle:
- If the address is in range and wstrb is all ones: write_en = 1, with write_addr and write_data taken from the latched beats.
- Otherwise: write_en = 0.
REQ-008 From W_WRITE the FSM SHALL enter W_RESP with bvalid = 1:
- bresp = 2'b00 (OKAY) if the write was performed, else 2'b10 (SLVERR).
- bvalid and bresp are held stable until bready; on bvalid&&bready the FSM returns to W_IDLE and clears both latches.
REQ-009 awready and wready SHALL be 0 in W_WRITE and W_RESP.
- Minimum write throughput is one write per 3 cycles with AW, W and bready all high.
REQ-010 The read path SHALL be an FSM with states R_IDLE, R_CAPTURE and R_DATA; arready = 1 only in R_IDLE.
REQ-011 On an AR handshake in cycle N, read_addr SHALL register the index and the FSM SHALL enter R_CAPTURE.
REQ-012 In cycle N+1 (R_CAPTURE), the block SHALL register s_axi_rdata and s_axi_rresp:
- In range: rdata = read_data, rresp = OKAY.
- Out of range: rdata = 0, rresp = SLVERR.
REQ-013 rvalid SHALL rise in cycle N+2 (R_DATA) and hold rdata/rresp stable until rready; on rvalid&&rready the FSM returns to R_IDLE.
REQ-014 The read and write FSMs SHALL operate concurrently and independently.
- If write_en to index k occurs in the same cycle as R_CAPTURE of index k, the read returns the pre-write value.
REQ-015 write_en SHALL never be asserted for two consecutive cycles, nor outside W_WRITE.
REQ-016 Response codes SHALL be limited to OKAY and SLVERR; bresp/rresp SHALL never equal 2'b01 or 2'b11.

Reset
REQ-017 While resetn = 0, the block SHALL hold all outputs at 0:
- awready, wready, arready, bvalid, rvalid, write_en = 0.
- bresp, rresp, rdata = 0; write_addr, write_data, read_addr = 0.
- Both FSMs are in their IDLE states and both AW/W latches are cleared.
REQ-018 In the first clock after resetn deasserts, awready, wready and arready SHALL be 1.
REQ-019 A reset asserted mid-transaction SHALL abandon that transaction:
- No write_en is produced for it, and no B or R response is issued for it after reset.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Write: AW(0x04) and W(0xDEADBEEF, strb 0xF) in the same cycle -> one-cycle write_en, write_addr = 1, write_data = 0xDEADBEEF; then bvalid with bresp = OKAY.
- Write-order independence: W(0x12345678) 3 cycles before AW(0x00) -> wready drops after the W handshake; write_en occurs 1 cycle after the AW handshake with write_addr = 0; bresp = OKAY.
- Error writes: awaddr = 0x40 (out of range) -> no write_en, bresp = SLVERR; wstrb = 0x3 at awaddr 0x08 -> no write_en, bresp = SLVERR, register 2 unchanged.
- Read: AR(0x04) at cycle N with register 1 = 0xDEADBEEF -> rvalid at N+2, rdata = 0xDEADBEEF, rresp = OKAY; rready held low 5 cycles -> rdata stable and arready = 0 throughout.
- Read/write collision: R_CAPTURE of index 3 coincides with write_en to index 3 of 0xAAAA5555 (old value 0x11) -> rdata = 0x11; a subsequent read returns 0xAAAA5555.
- Reset mid-operation: resetn pulled low during W_RESP and R_DATA -> bvalid = rvalid = 0 immediately; after release all readies = 1 and no stale response appears.
